// File: rtl/vehicle_request_gen_if.sv
// Sensor-side bus between the vehicle request conditioner and the traffic-light controller.
// The slave modport is the conditioner; the master is whoever drives the sensor and green flag.
interface vehicle_request_gen_if;
    logic       sensor_raw;
    logic       side_green;
    logic       x;
    logic       car_waiting;
    logic [7:0] detect_count;

    modport master (
        output sensor_raw,
        output side_green,
        input  x,
        input  car_waiting,
        input  detect_count
    );

    modport slave (
        input  sensor_raw,
        input  side_green,
        output x,
        output car_waiting,
        output detect_count
    );
endinterface

// File: rtl/vehicle_request_gen.sv
// Conditions the raw side-street sensor into a latched, minimum-hold request level x
// for the traffic-light controller, and counts accepted vehicles (saturating).
module vehicle_request_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    vehicle_request_gen_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             sync_p0;
    logic             sync_p1;
    logic             deb_p2;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             hold_load;
    logic             count_en;
    logic             x_d;
    logic             cw_d;
    logic             x_q;
    logic             cw_q;
    logic [7:0]       count_q;

    // Stage p0/p1: two-flop synchronizer for the asynchronous sensor
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.sensor_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounced level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            deb_p2 <= 1'b0;
            dcnt   <= '0;
        end else if (sync_p1 == deb_p2) begin
            dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
            deb_p2 <= sync_p1;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Request FSM: state register, with x/car_waiting registered from the next state
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            cw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cw_q    <= cw_d;
        end
    end

    // A request stays latched in REQ even if the car leaves; SERVE ends only when hold expired and sensor clear
    always_comb begin
        state_d   = IDLE;
        hold_load = 1'b0;
        count_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_p2) begin
                    state_d  = REQ;
                    count_en = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.side_green) begin
                    state_d   = SERVE;
                    hold_load = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            SERVE: begin
                if ((hcnt == '0) && !deb_p2) state_d = IDLE;
                else                         state_d = SERVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d  = (state_d == REQ) || (state_d == SERVE);
        cw_d = (state_d == REQ);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hcnt <= '0;
        end else if (hold_load) begin
            hcnt <= HOLD_LOAD;
        end else if ((state_q == SERVE) && (hcnt != '0)) begin
            hcnt <= hcnt - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q <= 8'd0;
        end else if (count_en) begin
            count_q <= sat_inc8(count_q);
        end
    end

    assign bus.x            = x_q;
    assign bus.car_waiting  = cw_q;
    assign bus.detect_count = count_q;

endmodule

// File: tb/tb_vehicle_request_gen.sv
// Directed bench for vehicle_request_gen: table-driven cycle vectors plus
// hand-written sequences for hold extension, simultaneous events, saturation and async clear.
module tb_vehicle_request_gen;

    logic clock;
    logic clear;
    int   tests;
    int   fails;

    vehicle_request_gen_if vif ();

    vehicle_request_gen #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .CNT_W          (4)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (vif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic       sensor;
        logic       green;
        int         reps;
        logic       ex;
        logic       ecw;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Inputs change just after an edge, so they are settled before the next one.
    task automatic step(input logic s, input logic g);
        vif.sensor_raw = s;
        vif.side_green = g;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_x(input logic s, input logic g, input logic val, input int max, input string name);
        int n;
        n = 0;
        while (vif.x !== val && n < max) begin
            step(s, g);
            n++;
        end
        tests++;
        if (vif.x !== val) begin
            fails++;
            $display("FAIL %s: x got %0b required %0b within %0d cycles", name, vif.x, val, max);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // sensor, green, reps, x, car_waiting, count (checked after every edge)
        vecs[0]  = '{1'b1, 1'b0,  6, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 8'd1};
        vecs[2]  = '{1'b1, 1'b0, 20, 1'b1, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 1'b0, 10, 1'b1, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{1'b0, 1'b1,  7, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b0,  3, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b0,  4, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 15, 1'b1, 1'b1, 8'd2};

        clear          = 1'b1;
        vif.sensor_raw = 1'b0;
        vif.side_green = 1'b0;
        #12;
        chk("reset_x",   {7'd0, vif.x},           8'd0);
        chk("reset_cw",  {7'd0, vif.car_waiting}, 8'd0);
        chk("reset_cnt", vif.detect_count,        8'd0);
        clear = 1'b0;

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step(vecs[i].sensor, vecs[i].green);
                chk($sformatf("vec%0d_r%0d_x", i, r),   {7'd0, vif.x},           {7'd0, vecs[i].ex});
                chk($sformatf("vec%0d_r%0d_cw", i, r),  {7'd0, vif.car_waiting}, {7'd0, vecs[i].ecw});
                chk($sformatf("vec%0d_r%0d_cnt", i, r), vif.detect_count,        vecs[i].ecnt);
            end
        end

        // Serve the request latched by the 4-cycle pulse
        wait_x(1'b0, 1'b1, 1'b0, 20, "serve_pulse_req");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Extended hold: sensor stays high through SERVE, green drops midway
        for (int e = 1; e <= 6; e++) begin
            step(1'b1, 1'b0);
            chk($sformatf("ext_rise_e%0d_x", e), {7'd0, vif.x}, 8'd0);
        end
        step(1'b1, 1'b0);
        chk("ext_rise_e7_x",  {7'd0, vif.x},           8'd1);
        chk("ext_rise_e7_cw", {7'd0, vif.car_waiting}, 8'd1);
        chk("ext_rise_cnt",   vif.detect_count,        8'd3);
        step(1'b1, 1'b1);
        chk("ext_serve_cw", {7'd0, vif.car_waiting}, 8'd0);
        for (int c = 0; c < 29; c++) begin
            step(1'b1, (c < 4) ? 1'b1 : 1'b0);
            chk($sformatf("ext_hold_c%0d_x", c), {7'd0, vif.x}, 8'd1);
        end
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 1'b0);
            chk($sformatf("ext_fall_e%0d_x", e), {7'd0, vif.x}, 8'd1);
        end
        step(1'b0, 1'b0);
        chk("ext_fall_e7_x",   {7'd0, vif.x},    8'd0);
        chk("ext_fall_cnt",    vif.detect_count, 8'd3);

        // side_green already high on the IDLE->REQ edge: REQ first, SERVE next edge
        for (int e = 1; e <= 6; e++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("simul_req_x",  {7'd0, vif.x},           8'd1);
        chk("simul_req_cw", {7'd0, vif.car_waiting}, 8'd1);
        step(1'b1, 1'b1);
        chk("simul_serve_x",  {7'd0, vif.x},           8'd1);
        chk("simul_serve_cw", {7'd0, vif.car_waiting}, 8'd0);
        chk("simul_cnt",      vif.detect_count,        8'd4);
        wait_x(1'b0, 1'b0, 1'b0, 20, "simul_release");
        step(1'b0, 1'b0);

        // Saturation: 300 further served requests
        for (int k = 0; k < 300; k++) begin
            wait_x(1'b1, 1'b0, 1'b1, 12, $sformatf("sat_req%0d", k));
            wait_x(1'b0, 1'b1, 1'b0, 30, $sformatf("sat_serve%0d", k));
            step(1'b0, 1'b0);
            if (k == 250) chk("sat_cnt_255_reached", vif.detect_count, 8'd255);
        end
        chk("sat_cnt_final", vif.detect_count, 8'd255);
        chk("sat_idle_x",    {7'd0, vif.x},    8'd0);

        // Asynchronous clear mid-cycle while in REQ
        wait_x(1'b1, 1'b0, 1'b1, 12, "clr_req");
        chk("clr_pre_cw", {7'd0, vif.car_waiting}, 8'd1);
        vif.sensor_raw = 1'b0;
        #3;
        clear = 1'b1;
        #1;
        chk("clr_x",   {7'd0, vif.x},           8'd0);
        chk("clr_cw",  {7'd0, vif.car_waiting}, 8'd0);
        chk("clr_cnt", vif.detect_count,        8'd0);
        #2;
        clear = 1'b0;
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);
        chk("post_clr_x",   {7'd0, vif.x},    8'd0);
        chk("post_clr_cnt", vif.detect_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
